// File: rtl/rv_opnd_bypass_pkg.sv
// Shared types for the ALU1 operand stage: bypass select struct, slot state, source indices.
package rv_opnd_bypass_pkg;

    localparam int unsigned RV_BP_NSRC = 4;

    // Counter/one-hot index order; lowest index is the highest-priority source
    localparam int unsigned RV_BP_SRC_ALU2    = 0;
    localparam int unsigned RV_BP_SRC_MEMORY  = 1;
    localparam int unsigned RV_BP_SRC_WRITE   = 2;
    localparam int unsigned RV_BP_SRC_WR_BACK = 3;

    typedef struct packed {
        logic alu2;
        logic memory;
        logic write;
        logic wr_back;
    } ctrl_rs_bp_t;

    typedef enum logic [1:0] {
        SLOT_EMPTY = 2'd0,
        SLOT_LIVE  = 2'd1,
        SLOT_HELD  = 2'd2
    } slot_state_e;

    // Priority-resolve a bypass select to one-hot: alu2 > memory > write > wr_back
    function automatic logic [RV_BP_NSRC-1:0] bp_winner(input ctrl_rs_bp_t bp);
        logic [RV_BP_NSRC-1:0] w;
        w = '0;
        if (bp.alu2)         w[RV_BP_SRC_ALU2]    = 1'b1;
        else if (bp.memory)  w[RV_BP_SRC_MEMORY]  = 1'b1;
        else if (bp.write)   w[RV_BP_SRC_WRITE]   = 1'b1;
        else if (bp.wr_back) w[RV_BP_SRC_WR_BACK] = 1'b1;
        return w;
    endfunction

endpackage

// File: rtl/rv_opnd_slot.sv
// One ALU1 operand slot: registered decode operand, bypass mux, and EMPTY/LIVE/HELD state.
module rv_opnd_slot
    import rv_opnd_bypass_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            dec_valid,
    input  logic [XLEN-1:0] dec_data,
    input  logic            stall,
    input  logic            flush,
    input  ctrl_rs_bp_t     bp,
    input  logic [XLEN-1:0] alu2_data,
    input  logic [XLEN-1:0] memory_data,
    input  logic [XLEN-1:0] write_data,
    input  logic [XLEN-1:0] wr_back_data,
    output slot_state_e     state,
    output logic [XLEN-1:0] rs_c
);

    slot_state_e           state_q, state_d;
    logic [XLEN-1:0]       opnd_q, opnd_d;
    logic [RV_BP_NSRC-1:0] win;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= SLOT_EMPTY;
            opnd_q  <= '0;
        end else begin
            state_q <= state_d;
            opnd_q  <= opnd_d;
        end
    end

    // Operand resolve: a held value ignores the bypass selects entirely
    always_comb begin
        win  = bp_winner(bp);
        rs_c = opnd_q;
        if (state_q != SLOT_HELD) begin
            if (win[RV_BP_SRC_ALU2])         rs_c = alu2_data;
            else if (win[RV_BP_SRC_MEMORY])  rs_c = memory_data;
            else if (win[RV_BP_SRC_WRITE])   rs_c = write_data;
            else if (win[RV_BP_SRC_WR_BACK]) rs_c = wr_back_data;
        end
    end

    // Flush beats stall; stall captures the resolved value so producers can move on
    always_comb begin
        state_d = state_q;
        opnd_d  = opnd_q;
        if (flush) begin
            state_d = SLOT_EMPTY;
            opnd_d  = '0;
        end else if (stall) begin
            opnd_d = rs_c;
            if (state_q == SLOT_LIVE) state_d = SLOT_HELD;
        end else begin
            opnd_d  = dec_data;
            state_d = dec_valid ? SLOT_LIVE : SLOT_EMPTY;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/rv_opnd_bypass.sv
// ALU1 operand stage: registers decode operands and applies ALU2/MEMORY/WRITE/WR_BACK forwarding.
// Optional bypass-hit counters under RV_BYPASS_PERF_EN.
module rv_opnd_bypass
    import rv_opnd_bypass_pkg::*;
#(
    parameter int unsigned XLEN   = 32
`ifdef RV_BYPASS_PERF_EN
   ,parameter int unsigned PERF_W = 32
`endif
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_dec_valid,
    input  logic [XLEN-1:0]   i_dec_rs1_data,
    input  logic [XLEN-1:0]   i_dec_rs2_data,
    input  logic              i_stall,
    input  logic              i_flush,
    input  ctrl_rs_bp_t       i_rs1_bp,
    input  ctrl_rs_bp_t       i_rs2_bp,
    input  logic [XLEN-1:0]   i_alu2_data,
    input  logic [XLEN-1:0]   i_memory_data,
    input  logic [XLEN-1:0]   i_write_data,
    input  logic [XLEN-1:0]   i_wr_back_data,
`ifdef RV_BYPASS_PERF_EN
    output logic [4*PERF_W-1:0] o_perf_bp_cnt,
`endif
    output logic              o_valid,
    output logic [XLEN-1:0]   o_rs1,
    output logic [XLEN-1:0]   o_rs2
);

    slot_state_e rs1_state, rs2_state;

    rv_opnd_slot #(.XLEN(XLEN)) u_rs1 (
        .clk          (i_clk),
        .reset_n      (i_reset_n),
        .dec_valid    (i_dec_valid),
        .dec_data     (i_dec_rs1_data),
        .stall        (i_stall),
        .flush        (i_flush),
        .bp           (i_rs1_bp),
        .alu2_data    (i_alu2_data),
        .memory_data  (i_memory_data),
        .write_data   (i_write_data),
        .wr_back_data (i_wr_back_data),
        .state        (rs1_state),
        .rs_c         (o_rs1)
    );

    rv_opnd_slot #(.XLEN(XLEN)) u_rs2 (
        .clk          (i_clk),
        .reset_n      (i_reset_n),
        .dec_valid    (i_dec_valid),
        .dec_data     (i_dec_rs2_data),
        .stall        (i_stall),
        .flush        (i_flush),
        .bp           (i_rs2_bp),
        .alu2_data    (i_alu2_data),
        .memory_data  (i_memory_data),
        .write_data   (i_write_data),
        .wr_back_data (i_wr_back_data),
        .state        (rs2_state),
        .rs_c         (o_rs2)
    );

    // Both slots move in lockstep; either one's state gives the instruction's validity
    assign o_valid = (rs1_state != SLOT_EMPTY) && (rs2_state != SLOT_EMPTY);

`ifdef RV_BYPASS_PERF_EN
    logic                  rs1_live, rs2_live;
    logic [RV_BP_NSRC-1:0] rs1_hit, rs2_hit;
    logic [PERF_W-1:0]     cnt_q [RV_BP_NSRC];

    // Only a live slot that actually advances this cycle consumes its source
    assign rs1_live = (rs1_state == SLOT_LIVE) && !i_stall && !i_flush;
    assign rs2_live = (rs2_state == SLOT_LIVE) && !i_stall && !i_flush;
    assign rs1_hit  = bp_winner(i_rs1_bp) & {RV_BP_NSRC{rs1_live}};
    assign rs2_hit  = bp_winner(i_rs2_bp) & {RV_BP_NSRC{rs2_live}};

    always_ff @(posedge i_clk) begin
        for (int i = 0; i < int'(RV_BP_NSRC); i++) begin
            if (!i_reset_n) cnt_q[i] <= '0;
            else            cnt_q[i] <= cnt_q[i] + PERF_W'(rs1_hit[i]) + PERF_W'(rs2_hit[i]);
        end
    end

    for (genvar g = 0; g < int'(RV_BP_NSRC); g++) begin : g_perf
        assign o_perf_bp_cnt[g*PERF_W +: PERF_W] = cnt_q[g];
    end
`endif

endmodule

// File: tb/tb_rv_opnd_bypass.sv
// Directed scoreboard bench for rv_opnd_bypass; counter checks only when RV_BYPASS_PERF_EN is defined.
module tb_rv_opnd_bypass;
    import rv_opnd_bypass_pkg::*;

    localparam int unsigned XLEN = 32;

    logic            i_clk = 1'b0;
    logic            i_reset_n;
    logic            i_dec_valid;
    logic [XLEN-1:0] i_dec_rs1_data, i_dec_rs2_data;
    logic            i_stall, i_flush;
    ctrl_rs_bp_t     i_rs1_bp, i_rs2_bp;
    logic [XLEN-1:0] i_alu2_data, i_memory_data, i_write_data, i_wr_back_data;
    logic            o_valid;
    logic [XLEN-1:0] o_rs1, o_rs2;
`ifdef RV_BYPASS_PERF_EN
    logic [4*32-1:0] o_perf_bp_cnt;
`endif

    typedef struct {
        logic            v;
        logic [XLEN-1:0] r1;
        logic [XLEN-1:0] r2;
        logic            chk_rs;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    rv_opnd_bypass #(.XLEN(XLEN)) dut (
        .i_clk          (i_clk),
        .i_reset_n      (i_reset_n),
        .i_dec_valid    (i_dec_valid),
        .i_dec_rs1_data (i_dec_rs1_data),
        .i_dec_rs2_data (i_dec_rs2_data),
        .i_stall        (i_stall),
        .i_flush        (i_flush),
        .i_rs1_bp       (i_rs1_bp),
        .i_rs2_bp       (i_rs2_bp),
        .i_alu2_data    (i_alu2_data),
        .i_memory_data  (i_memory_data),
        .i_write_data   (i_write_data),
        .i_wr_back_data (i_wr_back_data),
`ifdef RV_BYPASS_PERF_EN
        .o_perf_bp_cnt  (o_perf_bp_cnt),
`endif
        .o_valid        (o_valid),
        .o_rs1          (o_rs1),
        .o_rs2          (o_rs2)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Push the expectation for this cycle, compare at negedge, then advance past the next posedge
    task automatic step(input string tag, input logic ev, input logic [XLEN-1:0] e1,
                        input logic [XLEN-1:0] e2, input logic chk_rs);
        exp_t e;
        exp_q.push_back('{v: ev, r1: e1, r2: e2, chk_rs: chk_rs});
        @(negedge i_clk);
        e = exp_q.pop_front();
        chk({tag, "_valid"}, XLEN'(o_valid), XLEN'(e.v));
        if (e.chk_rs) begin
            chk({tag, "_rs1"}, o_rs1, e.r1);
            chk({tag, "_rs2"}, o_rs2, e.r2);
        end
        @(posedge i_clk);
        #1;
    endtask

`ifdef RV_BYPASS_PERF_EN
    task automatic chk_perf(input string tag, input logic [31:0] a, input logic [31:0] m,
                            input logic [31:0] w, input logic [31:0] b);
        logic [4*32-1:0] p;
        p = o_perf_bp_cnt;
        chk({tag, "_alu2"},    p[0*32 +: 32], a);
        chk({tag, "_memory"},  p[1*32 +: 32], m);
        chk({tag, "_write"},   p[2*32 +: 32], w);
        chk({tag, "_wr_back"}, p[3*32 +: 32], b);
    endtask
`endif

    initial begin
        #20000;
        n_fail++;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset_n      = 1'b0;
        i_dec_valid    = 1'b1;
        i_dec_rs1_data = 32'h5;
        i_dec_rs2_data = 32'h6;
        i_stall        = 1'b0;
        i_flush        = 1'b0;
        i_rs1_bp       = '0;
        i_rs2_bp       = '0;
        i_alu2_data    = '0;
        i_memory_data  = '0;
        i_write_data   = '0;
        i_wr_back_data = '0;
        @(posedge i_clk);
        #1;

        // Reset held with a valid decode
        step("reset1", 1'b0, 32'h0, 32'h0, 1'b1);
        step("reset2", 1'b0, 32'h0, 32'h0, 1'b1);
`ifdef RV_BYPASS_PERF_EN
        chk_perf("perf_reset", 0, 0, 0, 0);
`endif
        i_reset_n      = 1'b1;

        // Plain load, one-cycle latency
        i_dec_rs1_data = 32'h11;
        i_dec_rs2_data = 32'h22;
        step("preload", 1'b0, 32'h0, 32'h0, 1'b1);
        step("load", 1'b1, 32'h11, 32'h22, 1'b1);

        // Priority alu2 over wr_back
        i_rs1_bp       = '{alu2: 1'b1, memory: 1'b0, write: 1'b0, wr_back: 1'b1};
        i_alu2_data    = 32'hA;
        i_wr_back_data = 32'hB;
        i_dec_rs1_data = 32'h33;
        i_dec_rs2_data = 32'h44;
        step("prio", 1'b1, 32'hA, 32'h22, 1'b1);
`ifdef RV_BYPASS_PERF_EN
        chk_perf("perf_prio", 1, 0, 0, 0);
`endif

        // Stall capture of a memory forward
        i_rs1_bp       = '{alu2: 1'b0, memory: 1'b1, write: 1'b0, wr_back: 1'b0};
        i_memory_data  = 32'h55;
        i_stall        = 1'b1;
        step("stall1", 1'b1, 32'h55, 32'h44, 1'b1);
        i_memory_data  = 32'h99;
        step("stall2", 1'b1, 32'h55, 32'h44, 1'b1);
        i_rs1_bp       = '0;
        step("stall3", 1'b1, 32'h55, 32'h44, 1'b1);
        i_stall        = 1'b0;
        i_dec_rs1_data = 32'h66;
        i_dec_rs2_data = 32'h77;
        step("release", 1'b1, 32'h55, 32'h44, 1'b1);
`ifdef RV_BYPASS_PERF_EN
        chk_perf("perf_stall", 1, 0, 0, 0);
`endif

        // Flush and stall together: flush wins, decode data discarded
        i_stall        = 1'b1;
        i_flush        = 1'b1;
        i_dec_rs1_data = 32'hDE;
        i_dec_rs2_data = 32'hAD;
        step("reload", 1'b1, 32'h66, 32'h77, 1'b1);
        i_stall        = 1'b0;
        i_flush        = 1'b0;
        i_rs1_bp       = '{alu2: 1'b1, memory: 1'b0, write: 1'b0, wr_back: 1'b0};
        i_dec_rs1_data = 32'h1;
        i_dec_rs2_data = 32'hA1;
        step("flushed", 1'b0, 32'h0, 32'h0, 1'b0);

        // Back-to-back decodes with a write forward on the second
        i_rs1_bp       = '0;
        i_dec_rs1_data = 32'h2;
        i_dec_rs2_data = 32'hA2;
        step("b2b1", 1'b1, 32'h1, 32'hA1, 1'b1);
        i_rs1_bp       = '{alu2: 1'b0, memory: 1'b0, write: 1'b1, wr_back: 1'b0};
        i_write_data   = 32'h77;
        i_dec_rs1_data = 32'h3;
        i_dec_rs2_data = 32'hA3;
        step("b2b2", 1'b1, 32'h77, 32'hA2, 1'b1);
        i_rs1_bp       = '0;
        i_dec_valid    = 1'b0;
        step("b2b3", 1'b1, 32'h3, 32'hA3, 1'b1);

        // Both operands forwarding from alu2
        i_rs1_bp       = '{alu2: 1'b1, memory: 1'b0, write: 1'b0, wr_back: 1'b0};
        i_rs2_bp       = '{alu2: 1'b1, memory: 1'b0, write: 1'b0, wr_back: 1'b0};
        step("empty", 1'b0, 32'h0, 32'h0, 1'b0);
`ifdef RV_BYPASS_PERF_EN
        chk_perf("perf_final", 1, 0, 1, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
